cv32e40x_fetch_txn_scheduler: RTL and testbench

- Sequences instruction-fetch transactions between the prefetcher's transaction port and the OBI instruction bus.
- Holds a request stable until granted, as OBI requires.
- Limits outstanding (granted, unanswered) transactions to a parameterised maximum.
- On a pipeline flush, tracks and silently discards the responses to all pre-flush transactions, so the alignment buffer only sees the new stream.

---
 rtl/cv32e40x_fetch_txn_scheduler.sv | 147 ++++++++++++++
 tb/tb_cv32e40x_fetch_txn_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_fetch_txn_scheduler.sv
// Instruction-fetch transaction scheduler.
// Sits between the prefetcher's transaction port and the OBI instruction bus.
// It holds an ungranted request stable and caps the number of granted,
// unanswered transactions. Responses to transactions issued before a flush
// are tracked and discarded.
module cv32e40x_fetch_txn_scheduler #(
  parameter int MAX_OUTSTND = 2,
  parameter int CNT_WIDTH   = $clog2(MAX_OUTSTND + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 trans_valid_i,
  output logic                 trans_ready_o,
  input  logic [31:0]          trans_addr_i,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [31:0]          obi_addr_o,
  input  logic                 obi_rvalid_i,
  input  logic [31:0]          obi_rdata_i,
  input  logic                 obi_err_i,
  output logic                 resp_valid_o,
  output logic [31:0]          resp_rdata_o,
  output logic                 resp_err_o,
  output logic [CNT_WIDTH-1:0] outstnd_cnt_o,
  output logic                 busy_o
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTND);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_addr;
  logic                  r_kill;
  logic [CNT_WIDTH-1:0]  r_outstnd_cnt;
  logic [CNT_WIDTH-1:0]  r_drop_cnt;
  logic [CNT_WIDTH-1:0]  w_outstnd_nxt;
  logic [CNT_WIDTH-1:0]  w_drop_nxt;
  logic                  w_grant_fire;
  logic                  w_held_grant;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: an ungranted request parks in WAIT_GNT until granted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (obi_req_o && !obi_gnt_i) w_state_nxt = WAIT_GNT;
      WAIT_GNT: if (obi_gnt_i)               w_state_nxt = IDLE;
      default:                               w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: IDLE passes the request straight through, WAIT_GNT replays the held one
  always_comb begin
    trans_ready_o = 1'b0;
    obi_req_o     = 1'b0;
    obi_addr_o    = trans_addr_i;
    case (r_state)
      IDLE: begin
        trans_ready_o = (r_outstnd_cnt < MAX_CNT);
        obi_req_o     = trans_valid_i && trans_ready_o;
        obi_addr_o    = trans_addr_i;
      end
      WAIT_GNT: begin
        trans_ready_o = 1'b0;
        obi_req_o     = 1'b1;
        obi_addr_o    = r_addr;
      end
      default: begin
        trans_ready_o = 1'b0;
        obi_req_o     = 1'b0;
      end
    endcase
  end

  assign w_grant_fire = obi_req_o && obi_gnt_i;
  // A grant taken in WAIT_GNT belongs to a request accepted in an earlier cycle
  assign w_held_grant = w_grant_fire && (r_state == WAIT_GNT);

  // Counter next values; a flush turns everything still outstanding into drops,
  // except a response landing in the flush cycle, which is discarded directly
  always_comb begin
    w_outstnd_nxt = r_outstnd_cnt + CNT_WIDTH'(w_grant_fire) - CNT_WIDTH'(obi_rvalid_i);
    if (flush_i) begin
      w_drop_nxt = r_outstnd_cnt - CNT_WIDTH'(obi_rvalid_i) + CNT_WIDTH'(w_held_grant);
    end else begin
      w_drop_nxt = r_drop_cnt
                 - CNT_WIDTH'(obi_rvalid_i && (r_drop_cnt != '0))
                 + CNT_WIDTH'(w_held_grant && r_kill);
    end
  end

  // Held address and kill flag: captured on entry to WAIT_GNT, killed by a flush while held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_kill <= 1'b0;
    end else if ((r_state == IDLE) && obi_req_o && !obi_gnt_i) begin
      r_addr <= trans_addr_i;
      r_kill <= 1'b0;
    end else if ((r_state == WAIT_GNT) && flush_i) begin
      r_kill <= 1'b1;
    end
  end

  // Outstanding and drop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstnd_cnt <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstnd_cnt <= w_outstnd_nxt;
      r_drop_cnt    <= w_drop_nxt;
    end
  end

  assign resp_valid_o  = obi_rvalid_i && (r_drop_cnt == '0) && !flush_i;
  assign resp_rdata_o  = obi_rdata_i;
  assign resp_err_o    = obi_err_i;
  assign outstnd_cnt_o = r_outstnd_cnt;
  assign busy_o        = (r_state == WAIT_GNT) || (r_outstnd_cnt != '0);

  a_drop_le_outstnd: assert property (@(posedge clk) disable iff (!rst_n)
    r_drop_cnt <= r_outstnd_cnt);
  a_outstnd_le_max: assert property (@(posedge clk) disable iff (!rst_n)
    r_outstnd_cnt <= MAX_CNT);
  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(obi_rvalid_i && (r_outstnd_cnt == '0)));
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (obi_req_o && !obi_gnt_i) |=> $stable(obi_addr_o));
  a_no_grant_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_grant_fire && !obi_rvalid_i && (r_outstnd_cnt == MAX_CNT)));

endmodule

// File: tb/tb_cv32e40x_fetch_txn_scheduler.sv
// Bench for the fetch transaction scheduler: directed scenarios plus random
// traffic, compared against a transaction-queue reference model.
module tb_cv32e40x_fetch_txn_scheduler;

  localparam int MAX = 2;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic          trans_valid_i;
  logic          trans_ready_o;
  logic [31:0]   trans_addr_i;
  logic          obi_req_o;
  logic          obi_gnt_i;
  logic [31:0]   obi_addr_o;
  logic          obi_rvalid_i;
  logic [31:0]   obi_rdata_i;
  logic          obi_err_i;
  logic          resp_valid_o;
  logic [31:0]   resp_rdata_o;
  logic          resp_err_o;
  logic [CW-1:0] outstnd_cnt_o;
  logic          busy_o;

  cv32e40x_fetch_txn_scheduler #(.MAX_OUTSTND(MAX), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .trans_valid_i (trans_valid_i),
    .trans_ready_o (trans_ready_o),
    .trans_addr_i  (trans_addr_i),
    .obi_req_o     (obi_req_o),
    .obi_gnt_i     (obi_gnt_i),
    .obi_addr_o    (obi_addr_o),
    .obi_rvalid_i  (obi_rvalid_i),
    .obi_rdata_i   (obi_rdata_i),
    .obi_err_i     (obi_err_i),
    .resp_valid_o  (resp_valid_o),
    .resp_rdata_o  (resp_rdata_o),
    .resp_err_o    (resp_err_o),
    .outstnd_cnt_o (outstnd_cnt_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: in-order list of granted transactions plus the held request
  typedef struct {
    logic [31:0] addr;
    logic        killed;
  } txn_t;

  txn_t        q[$];
  logic        m_held;
  logic [31:0] m_haddr;
  logic        m_hkill;

  int n_tests = 0;
  int n_fail  = 0;
  int peak    = 0;
  int n_fwd   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]};
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return ^a[6:2];
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance the model
  task automatic cycle(input logic v, input logic [31:0] a, input logic g,
                       input logic rv, input logic fl);
    logic        e_ready, e_req, e_rvld, grant;
    logic [31:0] e_addr;
    int          e_cnt;
    txn_t        t;
    if (rv && (q.size() == 0)) rv = 1'b0;
    trans_valid_i = v;
    trans_addr_i  = a;
    obi_gnt_i     = g;
    obi_rvalid_i  = rv;
    flush_i       = fl;
    obi_rdata_i   = rv ? rd_of(q[0].addr) : 32'h0;
    obi_err_i     = rv ? err_of(q[0].addr) : 1'b0;
    @(negedge clk);
    e_cnt   = q.size();
    e_ready = !m_held && (e_cnt < MAX);
    e_req   = m_held ? 1'b1 : (v && e_ready);
    e_addr  = m_held ? m_haddr : a;
    e_rvld  = rv && !q[0].killed && !fl;
    chk("trans_ready", 32'(trans_ready_o), 32'(e_ready));
    chk("obi_req", 32'(obi_req_o), 32'(e_req));
    if (e_req) chk("obi_addr", obi_addr_o, e_addr);
    chk("resp_valid", 32'(resp_valid_o), 32'(e_rvld));
    if (e_rvld) begin
      chk("resp_rdata", resp_rdata_o, rd_of(q[0].addr));
      chk("resp_err", 32'(resp_err_o), 32'(err_of(q[0].addr)));
    end
    chk("outstnd_cnt", 32'(outstnd_cnt_o), 32'(e_cnt));
    chk("busy", 32'(busy_o), 32'(m_held || (e_cnt != 0)));
    if (int'(outstnd_cnt_o) > peak) peak = int'(outstnd_cnt_o);
    if (resp_valid_o) n_fwd++;
    grant = e_req && g;
    if (fl) begin
      foreach (q[i]) q[i].killed = 1'b1;
      if (m_held) m_hkill = 1'b1;
    end
    if (rv) void'(q.pop_front());
    if (grant) begin
      t.addr   = e_addr;
      t.killed = m_held ? m_hkill : 1'b0;
      q.push_back(t);
      m_held = 1'b0;
    end else if (e_req && !m_held) begin
      m_held  = 1'b1;
      m_haddr = a;
      m_hkill = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; trans_valid_i = 1'b0; trans_addr_i = '0;
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
    m_held = 1'b0; m_haddr = '0; m_hkill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 32'(outstnd_cnt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back requests, third stalls on the outstanding limit
    peak = 0; n_fwd = 0;
    cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h108, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h108, 1'b1, 1'b1, 1'b0);
    idle_cycle();
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("s1_peak", 32'(peak), 32'd2);
    chk("s1_fwd", 32'(n_fwd), 32'd3);

    // Grant withheld for three cycles
    cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Flush with two outstanding, new request waits for a free slot
    n_fwd = 0;
    cycle(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h800, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h800, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h800, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("s3_fwd", 32'(n_fwd), 32'd1);

    // Flush while a request is held
    n_fwd = 0;
    cycle(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h900, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h900, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h900, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("s4_fwd", 32'(n_fwd), 32'd1);

    // Flush coinciding with the only response
    cycle(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle_cycle();

    // Asynchronous reset with one outstanding and a held request
    cycle(1'b1, 32'h600, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h604, 1'b0, 1'b0, 1'b0);
    trans_valid_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; flush_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(outstnd_cnt_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_req", 32'(obi_req_o), 32'd0);
    chk("arst_ready", 32'(trans_ready_o), 32'd1);
    q.delete();
    m_held = 1'b0;
    m_hkill = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}[31:0],
            1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 11) == 0));
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("drain_cnt", 32'(outstnd_cnt_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
